sync_byte_packer: RTL
=====================

SYNC_BYTE_PACKER -- requirements
Module: sync_byte_packer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of one synchronized data beat.
REQ-002 SHALL have parameter NUM_BYTES, default 4, beats per packed word; legal range 2..8.
REQ-003 SHALL have port CLK  input  1  single destination-domain clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sync_bus  input  BUS_WIDTH  synchronized data beat; sampled only when enable_pulse=1.
REQ-006 SHALL have port enable_pulse  input  1  one-cycle pulse qualifying sync_bus; fed directly by the bus synchronizer.
REQ-007 SHALL have port packed_ready  input  1  downstream ready.
REQ-008 SHALL have port clear_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 SHALL have port packed_data  output  BUS_WIDTH*NUM_BYTES  assembled word.
REQ-010 SHALL have port packed_valid  output  1  packed_data holds an unconsumed word.
REQ-011 SHALL have port beat_cnt  output  clog2(NUM_BYTES)  beats collected toward the current word.
REQ-012 SHALL have port overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 Each cycle with enable_pulse=1 SHALL store sync_bus into assembly slot beat_cnt and increment beat_cnt; the first beat goes to the LSBs.
REQ-014 Cycles with enable_pulse=0 SHALL leave the assembly register and beat_cnt unchanged.
REQ-015 On the beat that makes beat_cnt reach NUM_BYTES, beat_cnt SHALL wrap to 0 and the word SHALL complete.
REQ-016 A completed word SHALL appear on packed_data with packed_valid=1 on the cycle after its last enable_pulse (1-cycle latency).
REQ-017 A transfer SHALL occur on a rising edge with packed_valid=1 and packed_ready=1; packed_valid SHALL drop on the next cycle unless REQ-018 applies.
REQ-018 If a word completes on the same edge as a transfer, the new word SHALL load and packed_valid SHALL stay 1.
REQ-019 While packed_valid=1 and no transfer occurs, packed_data SHALL hold stable.
REQ-020 If a word completes while packed_valid=1 and packed_ready=0, the new word SHALL be discarded, the held word kept, overflow set, and beat_cnt wrapped to 0.
REQ-021 clear_ovf=1 SHALL clear overflow on the next edge; if an overflow event occurs on the same edge, set SHALL win.
REQ-022 packed_ready SHALL be ignored while packed_valid=0.
REQ-023 Slots not yet written in the current word SHALL retain stale contents; only completed words are exposed.

Reset
REQ-024 With RST=0 at a rising edge, the block SHALL set packed_data=0, packed_valid=0, beat_cnt=0, overflow=0 and clear the assembly register.
REQ-025 Reset asserted mid-word SHALL discard the partial word; the first beat after release SHALL land in slot 0.
REQ-026 enable_pulse during a reset cycle SHALL be ignored.

Structure
REQ-027 The defaults for BUS_WIDTH and NUM_BYTES SHALL be constants in the shared package sync_pkg, alongside the synchronizer defaults.
REQ-028 The block SHALL be a single module with no sub-module; the assembly register, counter and output holding register are inline.

Verification
REQ-029 Reset, then 4 pulses with 0x11, 0x22, 0x33, 0x44 and packed_ready=1 -> one cycle after the 4th pulse, packed_data=0x44332211 and packed_valid=1 for exactly one cycle.
REQ-030 Pulses spaced 3 idle cycles apart with bytes 0xA0..0xA3 -> packed_data=0xA3A2A1A0; beat_cnt reads 1, 2, 3, 0.
REQ-031 packed_ready=0, two full words 0x04030201 then 0x08070605 -> packed_data stays 0x04030201, overflow=1, beat_cnt=0; packed_ready=1 then drains 0x04030201 only.
REQ-032 Valid word held; completing pulse coincides with packed_ready=1 -> old word transfers, new word loads, and packed_valid stays 1 with no gap.
REQ-033 2 beats sent, then RST=0 for one cycle, then 0x55, 0x66, 0x77, 0x88 -> packed_data=0x88776655 and no stale bytes.
REQ-034 overflow=1 and clear_ovf=1 asserted on the same edge as a new overflow -> overflow remains 1; clear_ovf alone on a later edge -> overflow=0.

Source files
------------

// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_pkg
//  Description : Shared constants for the clock-domain-crossing slice: the
//                bus synchronizer defaults and the byte packer defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    // Bus synchronizer defaults
    localparam int c_SYNC_STAGES    = 2;
    localparam int c_SYNC_BUS_WIDTH = 8;

    // Byte packer defaults: one packer beat is one synchronized bus word
    localparam int c_BUS_WIDTH      = c_SYNC_BUS_WIDTH;
    localparam int c_NUM_BYTES      = 4;

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sync_byte_packer
//  Description : Collects NUM_BYTES synchronized beats (first beat in the
//                LSBs) into one word and presents it on a valid/ready
//                holding register. A word that completes while the holding
//                register is full and not draining is dropped and flagged
//                in a sticky overflow bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_byte_packer
    import sync_pkg::*;
#(
    parameter int BUS_WIDTH = c_BUS_WIDTH,
    parameter int NUM_BYTES = c_NUM_BYTES
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [BUS_WIDTH-1:0]             sync_bus,
    input  logic                             enable_pulse,
    input  logic                             packed_ready,
    input  logic                             clear_ovf,
    output logic [BUS_WIDTH*NUM_BYTES-1:0]   packed_data,
    output logic                             packed_valid,
    output logic [$clog2(NUM_BYTES)-1:0]     beat_cnt,
    output logic                             overflow
);

    localparam int c_WORD_W = BUS_WIDTH * NUM_BYTES;
    localparam int c_CNT_W  = $clog2(NUM_BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(NUM_BYTES - 1);

    logic [c_WORD_W-1:0] r_asm;
    logic [c_WORD_W-1:0] r_data;
    logic [c_CNT_W-1:0]  r_beat_cnt;
    logic                r_valid;
    logic                r_overflow;

    logic [c_WORD_W-1:0] w_asm_next;
    logic                w_word_done;
    logic                w_xfer;
    logic                w_load;
    logic                w_ovf_event;

    // Assembly register as it will look after this cycle's beat (if any);
    // on the completing beat this is the finished word, so it can be
    // loaded into the holding register on the same edge.
    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (enable_pulse && (r_beat_cnt == c_CNT_W'(i))) begin
                w_asm_next[i*BUS_WIDTH +: BUS_WIDTH] = sync_bus;
            end
        end
    end

    // Handshake decode: ready only matters while a word is held, and a
    // completing word may reuse the slot being drained on the same edge.
    always_comb begin
        w_word_done = enable_pulse && (r_beat_cnt == c_LAST_BEAT);
        w_xfer      = r_valid && packed_ready;
        w_load      = w_word_done && (!r_valid || w_xfer);
        w_ovf_event = w_word_done && r_valid && !w_xfer;
    end

    // Beat counter and assembly register; idle cycles hold both.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_asm      <= '0;
            r_beat_cnt <= '0;
        end else if (enable_pulse) begin
            r_asm      <= w_asm_next;
            r_beat_cnt <= w_word_done ? '0 : r_beat_cnt + c_CNT_W'(1);
        end
    end

    // Output holding register with valid flag.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_asm_next;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear request.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_event) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign packed_data  = r_data;
    assign packed_valid = r_valid;
    assign beat_cnt     = r_beat_cnt;
    assign overflow     = r_overflow;

endmodule : sync_byte_packer
`default_nettype wire
